gcm_ctr_gen: RTL and testbench
==============================

# gcm_ctr_gen

GCM counter-block generator that feeds `ctr_block`/`ctr_valid` to the CTR XOR datapath and supplies the pre-counter block J0 to the tag stage. It holds a 96-bit IV and forms J0 = IV‖0x00000001. On each keystream request it issues the next counter, starting at inc32(J0), and enforces the GCM per-message block limit.

## Interface
- `MAX_BLOCKS`, default 32'hFFFF_FFFE: maximum counter blocks issued per message.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iv_in`  in  96  IV value. `iv_in[95:0]` maps to block bits [127:32].
- `iv_we`  in  1  capture `iv_in` into the IV register.
- `start`  in  1  begin a message using the stored IV.
- `msg_done`  in  1  end the current message.
- `keystream_req`  in  1  level request from the CTR XOR stage.
- `ctr_valid`  out  1  one-cycle pulse; `ctr_block` is valid.
- `ctr_block`  out  128  counter block handed to the CTR XOR stage.
- `j0_req`  in  1  tag stage requests J0.
- `j0_valid`  out  1  one-cycle pulse; `j0_block` is valid.
- `j0_block`  out  128  {IV of the current message, 32'h00000001}.
- `blk_count`  out  32  number of counter blocks issued in the current message.
- `busy`  out  1  high in ST_RUN.
- `ctr_exhausted`  out  1  sticky error flag.

## Operation
- **States:** ST_IDLE (no IV loaded), ST_READY (IV loaded), ST_RUN, ST_EXHAUST.
- **IV capture:** `iv_we` captures `iv_in` in any state. The new IV takes effect only at the next `start`. The first `iv_we` moves ST_IDLE to ST_READY.
- **start:**
  - Accepted in ST_READY, ST_RUN and ST_EXHAUST; ignored in ST_IDLE.
  - Latches msg_iv = IV register, ctr_reg = {IV, 32'h00000002}, blk_count = 0, `ctr_exhausted` = 0.
  - Goes to ST_RUN.
  - `start` in ST_RUN aborts the current message and restarts it.
- **Issue:** in ST_RUN, `keystream_req` high and `ctr_valid` low issues a counter on the next cycle:
  - `ctr_valid` = 1 and `ctr_block` = ctr_reg;
  - ctr_reg[31:0] increments modulo 2^32; bits [127:32] do not change;
  - `blk_count` increments.
- **No double issue:** `keystream_req` seen in the same cycle that `ctr_valid` is high does not issue a second counter.
- **Block limit:** a request in ST_RUN with `blk_count` == `MAX_BLOCKS`:
  - no `ctr_valid`;
  - `ctr_exhausted` is set;
  - go to ST_EXHAUST.
  - In ST_EXHAUST, requests are ignored.
- **msg_done:** in ST_RUN or ST_EXHAUST, go to ST_READY. `blk_count` and msg_iv are held for readback.
- **J0:** `j0_req` in ST_READY, ST_RUN or ST_EXHAUST pulses `j0_valid` the next cycle, with `j0_block` = {msg_iv, 32'h1}. This path is independent of the counter path; both may pulse in the same cycle.
- **Simultaneous events in ST_RUN (priority):** `start` > `msg_done` > `keystream_req`. A request in a `start` or `msg_done` cycle is dropped.
- **ST_IDLE:** `j0_req` and `keystream_req` are ignored.

## Timing
- **Reset values:**
  - state ST_IDLE;
  - `ctr_valid` 0, `j0_valid` 0, `busy` 0, `ctr_exhausted` 0;
  - `ctr_block`, `j0_block`, `blk_count` all 0;
  - IV register 0.
- **Reset mid-message:** returns to ST_IDLE. A new `iv_we` is required before the next `start`.
- **Latency:**
  - `keystream_req` → `ctr_valid`: 1 cycle, all outputs registered.
  - `start` → first request can be served: the cycle after `start`.
  - `j0_req` → `j0_valid`: 1 cycle.
- **Handshake with the CTR XOR stage:** it holds `keystream_req` high until it samples `ctr_valid`. `ctr_block` holds its value until the next issue.
- **Throughput:** at most one counter every 2 cycles. This matches the request/consume cadence of the consumer.

## Structure
- Shared package `gcm_pkg`:
  - state enum;
  - `GCM_J0_LSW` = 32'h1 and `GCM_CTR_FIRST_LSW` = 32'h2;
  - `GCM_MAX_BLOCKS_DEFAULT` = 32'hFFFF_FFFE;
  - function `inc32(block)`.
- No sub-module: one FSM plus registers.

## Test plan
- **Basic issue:** `iv_we` with IV = 96'hCAFEBABE_FACEDBAD_DECAF888, then `start`, then three requests → `ctr_block` LSWs are 0x00000002, 0x00000003, 0x00000004 with IV bits unchanged; `blk_count` = 3.
- **J0:** `j0_req` after `start` → `j0_block` = {IV, 32'h00000001}, 1 cycle later; concurrent with a `ctr_valid` pulse, both outputs are correct.
- **Block limit:** `MAX_BLOCKS` = 4 → five requests give 4 pulses, then `ctr_exhausted` = 1 in ST_EXHAUST; `start` clears the flag and the LSW restarts at 2.
- **Wrap-around:** force ctr_reg LSW = 32'hFFFF_FFFF → next block LSW = 0 and bits [127:32] are unchanged.
- **IV update during ST_RUN:** `iv_we` while running → `j0_block` keeps the old IV until the next `start`, then shows the new IV.
- **Reset and simultaneous events:**
  - `rst_n` low while running → all outputs 0, state ST_IDLE, `start` ignored until `iv_we`.
  - `start` and `keystream_req` in the same cycle → no `ctr_valid`.

Source files
------------

// File: rtl/gcm_ctr_gen_pkg.sv
// Shared GCM counter-generator types and constants.
package gcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READY   = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXHAUST = 2'd3
  } gcm_state_e;

  localparam logic [31:0] GCM_J0_LSW             = 32'h0000_0001;
  localparam logic [31:0] GCM_CTR_FIRST_LSW      = 32'h0000_0002;
  localparam logic [31:0] GCM_MAX_BLOCKS_DEFAULT = 32'hFFFF_FFFE;

  // Only the low word counts; it wraps without touching the IV bits.
  function automatic logic [127:0] inc32(input logic [127:0] block);
    return {block[127:32], block[31:0] + 32'd1};
  endfunction

endpackage

// File: rtl/gcm_ctr_gen_if.sv
// Control/data bundle between the counter generator and its GCM neighbours.
interface gcm_ctr_gen_if;
  logic [95:0]  iv_in;
  logic         iv_we;
  logic         start;
  logic         msg_done;
  logic         keystream_req;
  logic         ctr_valid;
  logic [127:0] ctr_block;
  logic         j0_req;
  logic         j0_valid;
  logic [127:0] j0_block;
  logic [31:0]  blk_count;
  logic         busy;
  logic         ctr_exhausted;

  modport master (
    output iv_in, iv_we, start, msg_done, keystream_req, j0_req,
    input  ctr_valid, ctr_block, j0_valid, j0_block, blk_count, busy, ctr_exhausted
  );

  modport slave (
    input  iv_in, iv_we, start, msg_done, keystream_req, j0_req,
    output ctr_valid, ctr_block, j0_valid, j0_block, blk_count, busy, ctr_exhausted
  );
endinterface

// File: rtl/gcm_ctr_gen.sv
// GCM counter-block generator: issues inc32 counters from J0 and serves J0 to the tag stage.
module gcm_ctr_gen
  import gcm_pkg::*;
#(
  parameter logic [31:0] MAX_BLOCKS = GCM_MAX_BLOCKS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  gcm_ctr_gen_if.slave   bus
);

  gcm_state_e   state;
  logic [95:0]  iv_reg;
  logic [95:0]  msg_iv;
  logic [127:0] ctr_reg;

  assign bus.busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      iv_reg            <= '0;
      msg_iv            <= '0;
      ctr_reg           <= '0;
      bus.ctr_valid     <= 1'b0;
      bus.ctr_block     <= '0;
      bus.j0_valid      <= 1'b0;
      bus.j0_block      <= '0;
      bus.blk_count     <= '0;
      bus.ctr_exhausted <= 1'b0;
    end else begin
      bus.ctr_valid <= 1'b0;
      bus.j0_valid  <= 1'b0;

      // New IV is staged only; msg_iv picks it up at the next start.
      if (bus.iv_we) iv_reg <= bus.iv_in;

      // J0 path runs alongside the counter path and reads the latched message IV.
      if (bus.j0_req && state != ST_IDLE) begin
        bus.j0_valid <= 1'b1;
        bus.j0_block <= {msg_iv, GCM_J0_LSW};
      end

      case (state)
        ST_IDLE: begin
          if (bus.iv_we) state <= ST_READY;
        end
        ST_READY, ST_RUN, ST_EXHAUST: begin
          if (bus.start) begin
            msg_iv            <= iv_reg;
            ctr_reg           <= {iv_reg, GCM_CTR_FIRST_LSW};
            bus.blk_count     <= '0;
            bus.ctr_exhausted <= 1'b0;
            state             <= ST_RUN;
          end else if (bus.msg_done && state != ST_READY) begin
            state <= ST_READY;
          end else if (state == ST_RUN && bus.keystream_req && !bus.ctr_valid) begin
            // Gating on ctr_valid stops a still-high request from being served twice.
            if (bus.blk_count == MAX_BLOCKS) begin
              bus.ctr_exhausted <= 1'b1;
              state             <= ST_EXHAUST;
            end else begin
              bus.ctr_valid <= 1'b1;
              bus.ctr_block <= ctr_reg;
              ctr_reg       <= inc32(ctr_reg);
              bus.blk_count <= bus.blk_count + 32'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_ctr_gen.sv
// Directed bench for gcm_ctr_gen with a queue of expected counter blocks.
module tb_gcm_ctr_gen;
  import gcm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcm_ctr_gen_if bus();

  gcm_ctr_gen #(.MAX_BLOCKS(32'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] model_ctr;
  logic [95:0]  iv_model;
  logic [95:0]  msg_iv_m;

  localparam logic [95:0] IV_A = 96'hCAFEBABE_FACEDBAD_DECAF888;
  localparam logic [95:0] IV_B = 96'hDEADBEEF_01234567_89ABCDEF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_iv(input logic [95:0] v);
    bus.iv_in = v;
    bus.iv_we = 1'b1;
    @(negedge clk);
    bus.iv_we = 1'b0;
    iv_model = v;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    msg_iv_m  = iv_model;
    model_ctr = {iv_model, 32'h0000_0002};
  endtask

  // Hold the request until ctr_valid is seen, then compare against the queue head.
  task automatic issue(input string tag);
    bit seen = 1'b0;
    bus.keystream_req = 1'b1;
    exp_q.push_back(model_ctr);
    model_ctr = {model_ctr[127:32], model_ctr[31:0] + 32'd1};
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.ctr_valid) seen = 1'b1;
    end
    bus.keystream_req = 1'b0;
    if (seen) chk(tag, bus.ctr_block, exp_q.pop_front());
    else begin
      chk({tag, "_timeout"}, 128'(bus.ctr_valid), 128'd1);
      void'(exp_q.pop_front());
    end
  endtask

  // Request that must not be served; the valid line is watched for several cycles.
  task automatic req_none(input string tag);
    logic any_valid = 1'b0;
    bus.keystream_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      any_valid |= bus.ctr_valid;
    end
    bus.keystream_req = 1'b0;
    chk(tag, 128'(any_valid), 128'd0);
  endtask

  task automatic j0_check(input string tag, input logic [95:0] iv);
    bus.j0_req = 1'b1;
    @(negedge clk);
    bus.j0_req = 1'b0;
    chk({tag, "_valid"}, 128'(bus.j0_valid), 128'd1);
    chk({tag, "_block"}, bus.j0_block, {iv, 32'h0000_0001});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iv_in = '0; bus.iv_we = 0; bus.start = 0; bus.msg_done = 0;
    bus.keystream_req = 0; bus.j0_req = 0;
    iv_model = '0; msg_iv_m = '0; model_ctr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctr_valid", 128'(bus.ctr_valid), 128'd0);
    chk("rst_ctr_block", bus.ctr_block, 128'd0);
    chk("rst_j0_block", bus.j0_block, 128'd0);
    chk("rst_blk_count", 128'(bus.blk_count), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_exhausted", 128'(bus.ctr_exhausted), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle: start and j0_req ignored before any IV
    bus.j0_req = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.j0_req = 1'b0; bus.start = 1'b0;
    chk("idle_j0_valid", 128'(bus.j0_valid), 128'd0);
    chk("idle_busy", 128'(bus.busy), 128'd0);

    // Basic issue
    load_iv(IV_A);
    do_start();
    chk("start_busy", 128'(bus.busy), 128'd1);
    issue("basic0");
    @(negedge clk);
    issue("basic1");
    @(negedge clk);
    issue("basic2");
    chk("basic_count", 128'(bus.blk_count), 128'd3);

    // J0 concurrent with a counter issue
    @(negedge clk);
    bus.j0_req = 1'b1;
    bus.keystream_req = 1'b1;
    exp_q.push_back(model_ctr);
    model_ctr = {model_ctr[127:32], model_ctr[31:0] + 32'd1};
    @(negedge clk);
    bus.j0_req = 1'b0;
    bus.keystream_req = 1'b0;
    chk("conc_j0_valid", 128'(bus.j0_valid), 128'd1);
    chk("conc_j0_block", bus.j0_block, {IV_A, 32'h0000_0001});
    chk("conc_ctr_valid", 128'(bus.ctr_valid), 128'd1);
    chk("conc_ctr_block", bus.ctr_block, exp_q.pop_front());

    // Block limit: four issued, fifth refused
    @(negedge clk);
    req_none("limit_no_valid");
    chk("limit_exhausted", 128'(bus.ctr_exhausted), 128'd1);
    chk("limit_busy", 128'(bus.busy), 128'd0);
    chk("limit_count", 128'(bus.blk_count), 128'd4);
    do_start();
    chk("restart_exh_clr", 128'(bus.ctr_exhausted), 128'd0);
    issue("restart0");

    // Counter wrap on the low word
    @(negedge clk);
    force dut.ctr_reg = {msg_iv_m, 32'hFFFF_FFFF};
    #1 release dut.ctr_reg;
    model_ctr = {msg_iv_m, 32'hFFFF_FFFF};
    issue("wrap_ffff");
    @(negedge clk);
    issue("wrap_zero");

    // msg_done holds readback values
    bus.msg_done = 1'b1;
    @(negedge clk);
    bus.msg_done = 1'b0;
    chk("done_busy", 128'(bus.busy), 128'd0);
    chk("done_count", 128'(bus.blk_count), 128'd3);
    j0_check("done_j0", IV_A);

    // IV update while running takes effect only at the next start
    do_start();
    load_iv(IV_B);
    j0_check("ivupd_old", IV_A);
    do_start();
    j0_check("ivupd_new", IV_B);
    issue("ivupd_ctr");

    // start and keystream_req in the same cycle: request dropped
    @(negedge clk);
    bus.start = 1'b1; bus.keystream_req = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.keystream_req = 1'b0;
    model_ctr = {iv_model, 32'h0000_0002};
    chk("start_req_valid", 128'(bus.ctr_valid), 128'd0);
    chk("start_req_count", 128'(bus.blk_count), 128'd0);

    // msg_done and keystream_req in the same cycle: request dropped
    bus.msg_done = 1'b1; bus.keystream_req = 1'b1;
    @(negedge clk);
    bus.msg_done = 1'b0; bus.keystream_req = 1'b0;
    chk("done_req_valid", 128'(bus.ctr_valid), 128'd0);
    chk("done_req_busy", 128'(bus.busy), 128'd0);

    // Reset mid-message
    do_start();
    issue("pre_reset");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_block", bus.ctr_block, 128'd0);
    chk("mid_rst_count", 128'(bus.blk_count), 128'd0);
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post_rst_start_ign", 128'(bus.busy), 128'd0);
    load_iv(IV_A);
    do_start();
    chk("post_rst_busy", 128'(bus.busy), 128'd1);
    issue("post_rst_ctr");

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
